pipe_in_verify: RTL and testbench

Parametrised Pipe In receive checker. Compares each written word against an internally generated reference pattern, counts errors and words, and captures the first mismatch. Models a throttled virtual FIFO that drives pipe_in_ready, so block-throttled host transfers can be exercised. Sits behind a Pipe In endpoint in the PipeTest sample designs.

---
 rtl/pipe_in_verify.sv | 154 +++++++++++++++
 tb/tb_pipe_in_verify.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_in_verify.sv
// Pipe In receive checker: compares incoming words against a reference pattern and
// models a throttled virtual FIFO. Optional first-error capture: PIPE_IN_ERR_CAPTURE_EN.
module pipe_in_verify #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH_LOG2   = 16,
  parameter int unsigned READY_MARGIN = 1024,
  parameter int unsigned THROTTLE_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_in_write,
  input  logic [WIDTH-1:0]      pipe_in_data,
  output logic                  pipe_in_ready,
  input  logic                  throttle_set,
  input  logic [THROTTLE_W-1:0] throttle_val,
  input  logic [2:0]            pattern,
  input  logic [31:0]           seed,
  output logic [31:0]           error_count,
  output logic [31:0]           word_count,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  first_err_valid,
  output logic [31:0]           first_err_index,
  output logic [WIDTH-1:0]      first_err_expected,
  output logic [WIDTH-1:0]      first_err_received
);

  localparam int unsigned LANES = WIDTH / 32;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LVL_W-1:0] LVL_READY = LVL_FULL - LVL_W'(READY_MARGIN);

  logic [2:0]            mode_q;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [WIDTH-1:0]      walk_q, walk_d;
  logic [31:0]           err_q, err_d;
  logic [31:0]           words_q, words_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  ready_q, ready_d;
  logic [THROTTLE_W-1:0] thr_q, thr_d;
  logic [WIDTH-1:0]      expected_c;
  logic                  mismatch_c;

  // Reference word derived from the generator state registers
  always_comb begin
    expected_c = '0;
    case (mode_q)
      3'd0: for (int unsigned k = 0; k < LANES; k++) expected_c[32*k +: 32] = cnt_q + 32'(k);
      3'd1: for (int unsigned k = 0; k < LANES; k++) expected_c[32*k +: 32] = lfsr_q ^ 32'(k);
      3'd2: expected_c = walk_q;
      3'd3: expected_c = ~walk_q;
      default: expected_c = '0;
    endcase
  end

  assign mismatch_c = pipe_in_write && (pipe_in_data != expected_c);

  always_comb begin
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    walk_d  = walk_q;
    err_d   = err_q;
    words_d = words_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    thr_d   = {thr_q[0], thr_q[THROTTLE_W-1:1]};
    ready_d = level_q < LVL_READY;

    if (pipe_in_write) begin
      cnt_d   = cnt_q + 32'(LANES);
      lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      walk_d  = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
      words_d = words_q + 32'd1;
      if (mismatch_c && (err_q != 32'hFFFF_FFFF)) err_d = err_q + 32'd1;
    end

    // Level moves on the throttle bit present before any load this cycle
    case ({pipe_in_write, thr_q[0]})
      2'b10: begin
        if (level_q == LVL_FULL) ovf_d = 1'b1;
        else                     level_d = level_q + LVL_W'(1);
      end
      2'b01: if (level_q != '0) level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (throttle_set) thr_d = throttle_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= pattern;
      cnt_q   <= '0;
      lfsr_q  <= (seed == 32'd0) ? 32'd1 : seed;
      walk_q  <= WIDTH'(1);
      err_q   <= '0;
      words_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      thr_q   <= throttle_val;
    end else begin
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      walk_q  <= walk_d;
      err_q   <= err_d;
      words_q <= words_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      thr_q   <= thr_d;
    end
  end

  assign pipe_in_ready = ready_q;
  assign error_count   = err_q;
  assign word_count    = words_q;
  assign level         = level_q;
  assign overflow      = ovf_q;

`ifdef PIPE_IN_ERR_CAPTURE_EN
  logic             fe_valid_q;
  logic [31:0]      fe_index_q;
  logic [WIDTH-1:0] fe_exp_q, fe_rcv_q;

  // Latch only the first mismatch after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fe_valid_q <= 1'b0;
      fe_index_q <= '0;
      fe_exp_q   <= '0;
      fe_rcv_q   <= '0;
    end else if (mismatch_c && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_index_q <= words_q;
      fe_exp_q   <= expected_c;
      fe_rcv_q   <= pipe_in_data;
    end
  end

  assign first_err_valid    = fe_valid_q;
  assign first_err_index    = fe_index_q;
  assign first_err_expected = fe_exp_q;
  assign first_err_received = fe_rcv_q;
`else
  assign first_err_valid    = 1'b0;
  assign first_err_index    = '0;
  assign first_err_expected = '0;
  assign first_err_received = '0;
`endif

endmodule

// File: tb/tb_pipe_in_verify.sv
// Directed bench for pipe_in_verify (WIDTH=64, 16-word virtual FIFO, ready margin 4).
module tb_pipe_in_verify;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_in_write;
  logic [63:0] pipe_in_data;
  logic        pipe_in_ready;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic [2:0]  pattern;
  logic [31:0] seed;
  logic [31:0] error_count;
  logic [31:0] word_count;
  logic [4:0]  level;
  logic        overflow;
  logic        first_err_valid;
  logic [31:0] first_err_index;
  logic [63:0] first_err_expected;
  logic [63:0] first_err_received;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_in_verify #(
    .WIDTH(64), .DEPTH_LOG2(4), .READY_MARGIN(4), .THROTTLE_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data), .pipe_in_ready(pipe_in_ready),
    .throttle_set(throttle_set), .throttle_val(throttle_val),
    .pattern(pattern), .seed(seed),
    .error_count(error_count), .word_count(word_count), .level(level), .overflow(overflow),
    .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .first_err_expected(first_err_expected), .first_err_received(first_err_received)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] p, input logic [31:0] s, input logic [31:0] tv);
    reset = 1'b1; pattern = p; seed = s; throttle_val = tv;
    step();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [63:0] d);
    pipe_in_write = 1'b1; pipe_in_data = d;
    step();
    pipe_in_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'd0, 32'd0, 32'd0);
    n_vec++; if (error_count !== 32'd0) begin n_err++; $display("FAIL reset_err got %0h exp 0", error_count); end
    n_vec++; if (word_count !== 32'd0) begin n_err++; $display("FAIL reset_words got %0h exp 0", word_count); end
    n_vec++; if (level !== 5'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_level got %0d/%b exp 0/0", level, overflow); end
    n_vec++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", pipe_in_ready); end
    n_vec++; if (first_err_valid !== 1'b0) begin n_err++; $display("FAIL reset_fe_valid got %b exp 0", first_err_valid); end
    step();
    n_vec++; if (pipe_in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b exp 1", pipe_in_ready); end
  endtask

  task automatic test_count();
    do_reset(3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) write_word({32'(2*i+1), 32'(2*i)});
    n_vec++; if (error_count !== 32'd0) begin n_err++; $display("FAIL count_err got %0d exp 0", error_count); end
    n_vec++; if (word_count !== 32'd8) begin n_err++; $display("FAIL count_words got %0d exp 8", word_count); end
    n_vec++; if (level !== 5'd8) begin n_err++; $display("FAIL count_level got %0d exp 8", level); end
  endtask

  task automatic test_lfsr();
    // seed 0 -> state 1; successive states 1, 3, 6, 0xD; lane1 = state ^ 1
    do_reset(3'd1, 32'd0, 32'd0);
    write_word(64'h00000000_00000001);
    write_word(64'h00000002_00000003);
    write_word(64'h00000007_00000026);
    write_word(64'h0000000C_0000000D);
    n_vec++; if (error_count !== 32'd1) begin n_err++; $display("FAIL lfsr_err got %0d exp 1", error_count); end
    n_vec++; if (word_count !== 32'd4) begin n_err++; $display("FAIL lfsr_words got %0d exp 4", word_count); end
`ifdef PIPE_IN_ERR_CAPTURE_EN
    n_vec++; if (first_err_valid !== 1'b1) begin n_err++; $display("FAIL fe_valid got %b exp 1", first_err_valid); end
    n_vec++; if (first_err_index !== 32'd2) begin n_err++; $display("FAIL fe_index got %0d exp 2", first_err_index); end
    n_vec++; if (first_err_expected !== 64'h00000007_00000006) begin n_err++; $display("FAIL fe_expected got %h exp 0000000700000006", first_err_expected); end
    n_vec++; if (first_err_received !== 64'h00000007_00000026) begin n_err++; $display("FAIL fe_received got %h exp 0000000700000026", first_err_received); end
`else
    n_vec++; if (first_err_valid !== 1'b0 || first_err_index !== 32'd0) begin n_err++; $display("FAIL fe_disabled got %b/%0h exp 0/0", first_err_valid, first_err_index); end
    n_vec++; if (first_err_expected !== 64'd0 || first_err_received !== 64'd0) begin n_err++; $display("FAIL fe_disabled_words got %h/%h exp 0/0", first_err_expected, first_err_received); end
`endif
  endtask

  task automatic test_modes();
    do_reset(3'd3, 32'd0, 32'd0);
    write_word(64'hFFFFFFFF_FFFFFFFE);
    write_word(64'hFFFFFFFF_FFFFFFFD);
    n_vec++; if (error_count !== 32'd0) begin n_err++; $display("FAIL walk0_ok got %0d exp 0", error_count); end
    write_word(64'hFFFFFFFF_FFFFFFF7);
    n_vec++; if (error_count !== 32'd1) begin n_err++; $display("FAIL walk0_bad got %0d exp 1", error_count); end
    do_reset(3'd5, 32'd0, 32'd0);
    write_word(64'd0);
    write_word(64'd0);
    n_vec++; if (error_count !== 32'd0 || word_count !== 32'd2) begin n_err++; $display("FAIL mode5 got %0d/%0d exp 0/2", error_count, word_count); end
  endtask

  task automatic test_level_ready();
    do_reset(3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      write_word({32'(2*i+1), 32'(2*i)});
      n_vec++; if (level !== 5'(i+1)) begin n_err++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i+1); end
      // ready reflects the level before this edge: high while that was < 12
      n_vec++; if (pipe_in_ready !== (i < 12)) begin n_err++; $display("FAIL fill_ready[%0d] got %b exp %b", i, pipe_in_ready, (i < 12)); end
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pre_overflow got %b exp 0", overflow); end
    write_word({32'd33, 32'd32});
    n_vec++; if (overflow !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL overflow got %b/%0d exp 1/16", overflow, level); end
    n_vec++; if (word_count !== 32'd17 || error_count !== 32'd0) begin n_err++; $display("FAIL over_counts got %0d/%0d exp 17/0", word_count, error_count); end
  endtask

  task automatic test_drain();
    throttle_set = 1'b1; throttle_val = 32'h0000_0001;
    step();
    throttle_set = 1'b0;
    repeat (32) step();
    n_vec++; if (level !== 5'd15) begin n_err++; $display("FAIL single_drain got %0d exp 15", level); end
    // load all ones; this edge still drains on the old bit 0 (which is set again)
    throttle_set = 1'b1; throttle_val = 32'hFFFF_FFFF;
    step();
    throttle_set = 1'b0;
    n_vec++; if (level !== 5'd14) begin n_err++; $display("FAIL load_drain got %0d exp 14", level); end
    for (int i = 13; i >= 0; i--) begin
      step();
      n_vec++; if (level !== 5'(i)) begin n_err++; $display("FAIL full_drain got %0d exp %0d", level, i); end
    end
    repeat (3) step();
    n_vec++; if (level !== 5'd0 || pipe_in_ready !== 1'b1) begin n_err++; $display("FAIL drain_hold got %0d/%b exp 0/1", level, pipe_in_ready); end
    // simultaneous load and write: old bit 0 = 1 cancels the increment
    throttle_set = 1'b1; throttle_val = 32'd0;
    write_word(64'd0);
    throttle_set = 1'b0;
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL set_and_write got %0d exp 0", level); end
    write_word(64'd0);
    n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL after_load got %0d exp 1", level); end
  endtask

  task automatic test_saturate();
    do_reset(3'd0, 32'd0, 32'd0);
    force dut.err_q = 32'hFFFF_FFFF;
    write_word(64'hFFFFFFFF_FFFFFFFF);
    release dut.err_q;
    n_vec++; if (error_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold got %h exp ffffffff", error_count); end
    write_word(64'hFFFFFFFF_FFFFFFFF);
    n_vec++; if (error_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_more got %h exp ffffffff", error_count); end
    n_vec++; if (word_count !== 32'd2) begin n_err++; $display("FAIL sat_words got %0d exp 2", word_count); end
  endtask

  task automatic test_reset_mid();
    do_reset(3'd0, 32'd0, 32'd0);
    write_word(64'h00000001_00000000);
    write_word(64'h00000003_00000002);
    write_word(64'hDEADBEEF_00000000);
    pipe_in_write = 1'b1; pipe_in_data = 64'h00000007_00000006;
    do_reset(3'd2, 32'd0, 32'd0);
    pipe_in_write = 1'b0;
    n_vec++; if (error_count !== 32'd0 || word_count !== 32'd0) begin n_err++; $display("FAIL mid_counts got %0d/%0d exp 0/0", error_count, word_count); end
    n_vec++; if (level !== 5'd0 || overflow !== 1'b0 || pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_level got %0d/%b/%b exp 0/0/0", level, overflow, pipe_in_ready); end
    n_vec++; if (first_err_valid !== 1'b0 || first_err_index !== 32'd0 || first_err_expected !== 64'd0 || first_err_received !== 64'd0) begin
      n_err++; $display("FAIL mid_fe got %b/%0h/%h/%h exp all 0", first_err_valid, first_err_index, first_err_expected, first_err_received);
    end
    write_word(64'h00000000_00000001);
    write_word(64'h00000000_00000002);
    n_vec++; if (error_count !== 32'd0) begin n_err++; $display("FAIL walk1_ok got %0d exp 0", error_count); end
    write_word(64'h00000000_00000008);
    n_vec++; if (error_count !== 32'd1) begin n_err++; $display("FAIL walk1_bad got %0d exp 1", error_count); end
  endtask

  initial begin
    reset = 1'b0; pipe_in_write = 1'b0; pipe_in_data = '0;
    throttle_set = 1'b0; throttle_val = '0; pattern = '0; seed = '0;
    step();
    test_reset();
    test_count();
    test_lfsr();
    test_modes();
    test_level_ready();
    test_drain();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
